// File: rtl/clcd_text_sequencer.sv
// clcd_text_sequencer: drives a character-LCD signal generator one byte at a time.
// After an init command list it refreshes a ROWSxCOLS text frame, either back-to-back
// or once per update request, from a snapshot of the text taken at frame start.
module clcd_text_sequencer #(
  parameter int unsigned ROWS      = 2,
  parameter int unsigned COLS      = 16,
  parameter logic [31:0] ROW_ADDR  = 32'h54_14_40_00,
  parameter logic [31:0] INIT_CMDS = 32'h38_0C_01_06
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [8*ROWS*COLS-1:0] text,
  input  logic                   empty_reg,
  input  logic                   auto_refresh,
  input  logic                   update,
  input  logic                   busy_CLCD,
  output logic [7:0]             data_CLCD,
  output logic                   RS_CLCD,
  output logic                   RW_CLCD,
  output logic                   valid_CLCD,
  output logic                   frame_done,
  output logic                   init_done
);

  localparam int unsigned NumChars = ROWS * COLS;
  localparam int unsigned RowW     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned ColW     = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [RowW-1:0] RowLast = RowW'(ROWS - 1);
  localparam logic [ColW-1:0] ColLast = ColW'(COLS - 1);

  typedef enum logic [2:0] {
    StWaitReady,
    StInit,
    StIdle,
    StSetAddr,
    StWrite,
    StNextRow
  } state_e;

  state_e                 state_q, state_d;
  logic                   busy_q;        // busy_CLCD delayed one cycle
  logic                   valid_q, valid_d;
  logic                   acc_q, acc_d;  // byte accepted, waiting for completion
  logic [7:0]             data_q, data_d;
  logic                   rs_q, rs_d;
  logic                   frame_done_q, frame_done_d;
  logic                   init_done_q, init_done_d;
  logic                   pending_q, pending_d;
  logic [RowW-1:0]        row_q, row_d;
  logic [ColW-1:0]        col_q, col_d;
  logic [1:0]             init_idx_q, init_idx_d;
  logic [8*NumChars-1:0]  snap_q, snap_d;

  logic                   pedge, nedge, byte_done, byte_idle;
  logic                   send;
  logic                   send_rs;
  logic [7:0]             send_byte;
  logic [7:0]             init_byte;
  logic [7:0]             row_addr;
  logic [7:0]             snap_byte;
  int unsigned            char_idx;

  assign pedge     = busy_CLCD & ~busy_q;
  assign nedge     = ~busy_CLCD & busy_q;
  // A falling edge only counts when a byte was actually accepted.
  assign byte_done = nedge & acc_q;
  // No byte in flight: free to present the next one.
  assign byte_idle = ~valid_q & ~acc_q;

  // Byte sources: init command, row address command and snapshot character.
  always_comb begin
    init_byte = 8'h00;
    unique case (init_idx_q)
      2'd0: init_byte = INIT_CMDS[31:24];
      2'd1: init_byte = INIT_CMDS[23:16];
      2'd2: init_byte = INIT_CMDS[15:8];
      2'd3: init_byte = INIT_CMDS[7:0];
      default: init_byte = 8'h00;
    endcase

    row_addr = 8'h00;
    for (int r = 0; r < 4; r++) begin
      if (32'(row_q) == r) row_addr = ROW_ADDR[8*r +: 8];
    end

    // Row 0 column 0 sits in the top byte, row-major descending.
    char_idx  = NumChars - 1 - (32'(row_q) * COLS + 32'(col_q));
    snap_byte = snap_q[8*char_idx +: 8];
  end

  // Next-state logic for the sequencer and the byte handshake.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    acc_d        = acc_q;
    data_d       = data_q;
    rs_d         = rs_q;
    frame_done_d = 1'b0;
    init_done_d  = init_done_q;
    pending_d    = pending_q;
    row_d        = row_q;
    col_d        = col_q;
    init_idx_d   = init_idx_q;
    snap_d       = snap_q;
    send         = 1'b0;
    send_rs      = 1'b0;
    send_byte    = 8'h00;

    if (valid_q && pedge) begin
      valid_d = 1'b0;
      acc_d   = 1'b1;
    end
    if (byte_done) acc_d = 1'b0;

    if (update) pending_d = 1'b1;

    unique case (state_q)
      StWaitReady: begin
        if (empty_reg) begin
          init_idx_d = 2'd0;
          state_d    = StInit;
        end
      end
      StInit: begin
        send      = 1'b1;
        send_byte = init_byte;
        if (byte_done) begin
          if (init_idx_q == 2'd3) begin
            init_done_d = 1'b1;
            state_d     = StIdle;
          end else begin
            init_idx_d = init_idx_q + 2'd1;
          end
        end
      end
      StIdle: begin
        // A coincident update is served by this frame, so pending ends up clear.
        if (auto_refresh || pending_q || update) begin
          snap_d    = text;
          pending_d = 1'b0;
          row_d     = '0;
          col_d     = '0;
          state_d   = StSetAddr;
        end
      end
      StSetAddr: begin
        send      = 1'b1;
        send_byte = 8'h80 | row_addr;
        if (byte_done) begin
          col_d   = '0;
          state_d = StWrite;
        end
      end
      StWrite: begin
        send      = 1'b1;
        send_rs   = 1'b1;
        send_byte = snap_byte;
        if (byte_done) begin
          if (col_q == ColLast) state_d = StNextRow;
          else                  col_d   = col_q + ColW'(1);
        end
      end
      StNextRow: begin
        if (row_q == RowLast) begin
          frame_done_d = 1'b1;
          state_d      = StIdle;
        end else begin
          row_d   = row_q + RowW'(1);
          state_d = StSetAddr;
        end
      end
      default: state_d = StWaitReady;
    endcase

    // Present a new byte only once the previous one has fully completed.
    if (send && byte_idle) begin
      valid_d = 1'b1;
      data_d  = send_byte;
      rs_d    = send_rs;
    end
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StWaitReady;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      acc_q        <= 1'b0;
      data_q       <= 8'h00;
      rs_q         <= 1'b0;
      frame_done_q <= 1'b0;
      init_done_q  <= 1'b0;
      pending_q    <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      init_idx_q   <= 2'd0;
      snap_q       <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_CLCD;
      valid_q      <= valid_d;
      acc_q        <= acc_d;
      data_q       <= data_d;
      rs_q         <= rs_d;
      frame_done_q <= frame_done_d;
      init_done_q  <= init_done_d;
      pending_q    <= pending_d;
      row_q        <= row_d;
      col_q        <= col_d;
      init_idx_q   <= init_idx_d;
      snap_q       <= snap_d;
    end
  end

  assign data_CLCD  = data_q;
  assign RS_CLCD    = rs_q;
  assign RW_CLCD    = 1'b0;
  assign valid_CLCD = valid_q;
  assign frame_done = frame_done_q;
  assign init_done  = init_done_q;

endmodule

// File: tb/tb_clcd_text_sequencer.sv
// Directed bench for clcd_text_sequencer: default 2x16 instance plus a 4x20 instance,
// sharing one signal-generator model that logs every completed byte as {RS, data}.
module tb_clcd_text_sequencer;

  localparam logic [127:0] T0R0 = "HELLO, WORLD!!!!";
  localparam logic [127:0] T0R1 = "0123456789ABCDEF";
  localparam logic [127:0] T1R0 = "GOODBYE, MOON...";
  localparam logic [127:0] T1R1 = "fedcba9876543210";
  localparam logic [159:0] U0   = "ROW0:abcdefghijklmno";
  localparam logic [159:0] U1   = "ROW1:abcdefghijklmno";
  localparam logic [159:0] U2   = "ROW2:abcdefghijklmno";
  localparam logic [159:0] U3   = "ROW3:abcdefghijklmno";

  logic         clk;
  logic         reset_n1, empty1, auto1, update1, busy1;
  logic [255:0] text1;
  logic [7:0]   d1;
  logic         rs1, rw1, v1, fd1, id1;

  logic         reset_n2, empty2, auto2, update2, busy2;
  logic [639:0] text2;
  logic [7:0]   d2;
  logic         rs2, rw2, v2, fd2, id2;

  logic         sel, busy;
  logic         m_valid, m_rs, m_rst;
  logic [7:0]   m_data;
  logic [8:0]   cap;
  logic         ok;
  logic [8:0]   log[$];

  int n_cmp, n_err, viol, fd1_cnt, fd2_cnt, fd1_at, fd_base;

  clcd_text_sequencer dut1 (
    .clk         (clk),
    .reset_n     (reset_n1),
    .text        (text1),
    .empty_reg   (empty1),
    .auto_refresh(auto1),
    .update      (update1),
    .busy_CLCD   (busy1),
    .data_CLCD   (d1),
    .RS_CLCD     (rs1),
    .RW_CLCD     (rw1),
    .valid_CLCD  (v1),
    .frame_done  (fd1),
    .init_done   (id1)
  );

  clcd_text_sequencer #(
    .ROWS(4),
    .COLS(20)
  ) dut2 (
    .clk         (clk),
    .reset_n     (reset_n2),
    .text        (text2),
    .empty_reg   (empty2),
    .auto_refresh(auto2),
    .update      (update2),
    .busy_CLCD   (busy2),
    .data_CLCD   (d2),
    .RS_CLCD     (rs2),
    .RW_CLCD     (rw2),
    .valid_CLCD  (v2),
    .frame_done  (fd2),
    .init_done   (id2)
  );

  assign busy1   = sel ? 1'b0 : busy;
  assign busy2   = sel ? busy : 1'b0;
  assign m_valid = sel ? v2 : v1;
  assign m_rs    = sel ? rs2 : rs1;
  assign m_data  = sel ? d2 : d1;
  assign m_rst   = sel ? reset_n2 : reset_n1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Signal generator: busy rises 3 cycles after valid, falls 2 cycles later.
  initial begin
    busy = 1'b0;
    forever begin
      @(negedge clk);
      if (m_valid && m_rst) begin
        ok = 1'b1;
        repeat (2) begin
          @(negedge clk);
          if (!m_rst) ok = 1'b0;
        end
        if (ok) begin
          cap  = {m_rs, m_data};
          busy = 1'b1;
          @(negedge clk);
          if (m_rst && m_valid) viol++;
          @(negedge clk);
          if (!m_rst) ok = 1'b0;
          else if ({m_rs, m_data} != cap) viol++;
          busy = 1'b0;
          if (ok) log.push_back(cap);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (fd1) begin
      fd1_cnt++;
      fd1_at = log.size();
    end
    if (fd2) fd2_cnt++;
  end

  task automatic check_eq(input string tag, input logic [639:0] got, input logic [639:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_bytes(input string tag, input int n);
    int budget;
    budget = n * 12 + 100;
    while (log.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_eq(tag, 640'(log.size()), 640'(n));
  endtask

  task automatic pulse1();
    update1 = 1'b1;
    @(negedge clk);
    update1 = 1'b0;
  endtask

  function automatic logic [639:0] row_str(input int start, input int len);
    logic [639:0] r;
    r = '0;
    for (int i = 0; i < len; i++) r = (r << 8) | 640'(log[start+i][7:0]);
    return r;
  endfunction

  function automatic logic [639:0] rs_bits(input int start, input int len);
    logic [639:0] r;
    r = '0;
    for (int i = 0; i < len; i++) r = (r << 1) | 640'(log[start+i][8]);
    return r;
  endfunction

  initial begin
    int b;
    n_cmp = 0; n_err = 0; viol = 0; fd1_cnt = 0; fd2_cnt = 0; fd1_at = 0; fd_base = 0;
    sel = 1'b0; reset_n1 = 1'b0; reset_n2 = 1'b0;
    empty1 = 1'b0; empty2 = 1'b0; auto1 = 1'b0; auto2 = 1'b0;
    update1 = 1'b0; update2 = 1'b0;
    text1 = {T0R0, T0R1};
    text2 = {U0, U1, U2, U3};

    cyc(3);
    check_eq("reset_outputs", 640'({id1, fd1, v1, rw1, rs1, d1}), 640'(13'h0));
    reset_n1 = 1'b1;
    cyc(6);
    check_eq("wait_ready_hold", 640'(v1), 640'(1'b0));

    // Init command list
    empty1 = 1'b1;
    wait_bytes("init_count", 4);
    check_eq("init_bytes", 640'({log[0], log[1], log[2], log[3]}),
             640'({9'h038, 9'h00C, 9'h001, 9'h006}));
    cyc(3);
    check_eq("init_done", 640'(id1), 640'(1'b1));
    cyc(60);
    check_eq("no_refresh_idle", 640'(log.size()), 640'(4));

    // Single update -> one 34-byte frame
    log.delete();
    fd_base = fd1_cnt;
    pulse1();
    wait_bytes("frame1_count", 34);
    cyc(3);
    check_eq("frame_done_after_last", 640'(fd1_at), 640'(34));
    cyc(100);
    check_eq("frame1_no_extra", 640'(log.size()), 640'(34));
    check_eq("frame1_done_pulses", 640'(fd1_cnt - fd_base), 640'(1));
    check_eq("row0_cmd", 640'(log[0]), 640'(9'h080));
    check_eq("row0_text", row_str(1, 16), 640'(T0R0));
    check_eq("row0_rs", rs_bits(1, 16), 640'(16'hFFFF));
    check_eq("row1_cmd", 640'(log[17]), 640'(9'h0C0));
    check_eq("row1_text", row_str(18, 16), 640'(T0R1));

    // Two updates during a frame -> exactly one further frame
    log.delete();
    fd_base = fd1_cnt;
    pulse1();
    wait_bytes("dbl_a", 8);
    pulse1();
    wait_bytes("dbl_b", 20);
    pulse1();
    wait_bytes("dbl_count", 68);
    cyc(150);
    check_eq("dbl_no_extra", 640'(log.size()), 640'(68));
    check_eq("dbl_done_pulses", 640'(fd1_cnt - fd_base), 640'(2));

    // Text change mid-frame: current frame keeps snapshot, next frame picks up new text
    log.delete();
    pulse1();
    wait_bytes("snap_start", 6);
    text1 = {T1R0, T1R1};
    pulse1();
    wait_bytes("snap_count", 68);
    check_eq("snap_old_row0", row_str(1, 16), 640'(T0R0));
    check_eq("snap_old_row1", row_str(18, 16), 640'(T0R1));
    check_eq("snap_new_row0", row_str(35, 16), 640'(T1R0));
    check_eq("snap_new_row1", row_str(52, 16), 640'(T1R1));
    cyc(100);

    // Auto refresh: next frame starts right after frame_done
    log.delete();
    fd_base = fd1_cnt;
    auto1 = 1'b1;
    wait_bytes("auto_count", 35);
    check_eq("auto_next_cmd", 640'(log[34]), 640'(9'h080));
    check_eq("auto_done_pulse", 640'(fd1_cnt - fd_base), 640'(1));
    auto1 = 1'b0;
    b = 600;
    while (fd1_cnt - fd_base < 2 && b > 0) begin
      @(negedge clk);
      b--;
    end
    cyc(60);
    check_eq("auto_stop_count", 640'(log.size()), 640'(68));

    // Reset while a character byte is requested
    auto1 = 1'b1;
    b = 600;
    while (!(v1 && rs1) && b > 0) begin
      @(negedge clk);
      b--;
    end
    check_eq("reached_write", 640'(v1 & rs1), 640'(1'b1));
    reset_n1 = 1'b0;
    cyc(1);
    check_eq("reset_mid_write", 640'({id1, fd1, v1, rw1, rs1, d1}), 640'(13'h0));
    empty1 = 1'b0;
    auto1  = 1'b0;
    cyc(3);
    log.delete();
    reset_n1 = 1'b1;
    cyc(8);
    check_eq("reinit_wait_ready", 640'(v1), 640'(1'b0));
    empty1 = 1'b1;
    wait_bytes("reinit_count", 4);
    check_eq("reinit_bytes", 640'({log[0], log[1], log[2], log[3]}),
             640'({9'h038, 9'h00C, 9'h001, 9'h006}));
    cyc(20);

    // 4x20 instance
    sel = 1'b1;
    log.delete();
    reset_n2 = 1'b1;
    empty2   = 1'b1;
    wait_bytes("d2_init_count", 4);
    log.delete();
    cyc(3);
    update2 = 1'b1;
    cyc(1);
    update2 = 1'b0;
    wait_bytes("d2_frame_count", 84);
    check_eq("d2_row0_cmd", 640'(log[0]), 640'(9'h080));
    check_eq("d2_row1_cmd", 640'(log[21]), 640'(9'h0C0));
    check_eq("d2_row2_cmd", 640'(log[42]), 640'(9'h094));
    check_eq("d2_row3_cmd", 640'(log[63]), 640'(9'h0D4));
    check_eq("d2_row2_text", row_str(43, 20), 640'(U2));
    check_eq("d2_row3_text", row_str(64, 20), 640'(U3));
    cyc(60);
    check_eq("d2_done_pulses", 640'(fd2_cnt), 640'(1));
    check_eq("d2_no_extra", 640'(log.size()), 640'(84));

    check_eq("handshake_violations", 640'(viol), 640'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
